// File: rtl/riscv_mem_pkg.sv
// Shared memory-access definitions: size encodings, responder state
// encoding, and the byte-lane mask / load-extension helpers that the
// memory-access stage and the data-memory responder both use.
package riscv_mem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Byte-enable mask for an access of 2^size bytes starting at byte lane 'lane'.
  function automatic logic [7:0] byte_mask(input logic [1:0] size, input logic [2:0] lane);
    logic [7:0] m;
    case (size)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << lane;
  endfunction

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_mask(input logic [1:0] size);
    logic [2:0] m;
    case (size)
      SZ_B:    m = 3'b000;
      SZ_H:    m = 3'b001;
      SZ_W:    m = 3'b011;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

  // Extend the low 2^size bytes of 'raw' to 64 bits; doubles are returned as-is.
  function automatic logic [63:0] load_extend(input logic [63:0] raw, input logic [1:0] size,
                                              input logic is_unsigned);
    logic [63:0] r;
    case (size)
      SZ_B:    r = {{56{~is_unsigned & raw[7]}},  raw[7:0]};
      SZ_H:    r = {{48{~is_unsigned & raw[15]}}, raw[15:0]};
      SZ_W:    r = {{32{~is_unsigned & raw[31]}}, raw[31:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the memory-access stage (master) and the
// data-memory responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/dmem_array.sv
// DEPTH x 64-bit storage with per-byte write enables and a registered
// (synchronous) read port. Contents and read register are not reset.
module dmem_array #(
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [7:0]    i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [63:0]   i_wdata,
  output logic [63:0]   o_rdata
);

  logic [63:0] r_mem [DEPTH];
  logic [63:0] r_rdata;

  // Byte-lane writes and registered read; read data holds until the next read.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 8; b++) begin
      if (i_we[b]) begin
        r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
    if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits a fixed
// LATENCY, performs the array access on the edge entering RESP and holds
// the response until the pipeline takes it.
module dmem_responder
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e        r_state, w_next_state;
  logic [CW-1:0] r_cnt;
  logic          w_accept, w_enter_resp;

  logic          r_write, r_unsigned, r_err;
  logic [1:0]    r_size;
  logic [2:0]    r_lane;
  logic [AW-1:0] r_idx;
  logic [63:0]   r_wdata;

  logic          w_req_err;
  logic          w_cur_write, w_cur_err;
  logic [1:0]    w_cur_size;
  logic [2:0]    w_cur_lane;
  logic [AW-1:0] w_cur_idx;
  logic [63:0]   w_cur_wdata;

  logic [7:0]    w_we;
  logic          w_re;
  logic [63:0]   w_dout;

  // Misaligned or beyond-the-array requests are flagged when presented.
  assign w_req_err = (|(bus.req_addr[2:0] & align_mask(bus.req_size))) |
                     (|bus.req_addr[63:3+AW]);

  // With LATENCY=1 the access happens on the accept edge, so the fields come
  // straight from the request; otherwise from the latched copy.
  assign w_cur_write = (r_state == IDLE) ? bus.req_write          : r_write;
  assign w_cur_err   = (r_state == IDLE) ? w_req_err              : r_err;
  assign w_cur_size  = (r_state == IDLE) ? bus.req_size           : r_size;
  assign w_cur_lane  = (r_state == IDLE) ? bus.req_addr[2:0]      : r_lane;
  assign w_cur_idx   = (r_state == IDLE) ? bus.req_addr[3 +: AW]  : r_idx;
  assign w_cur_wdata = (r_state == IDLE) ? bus.req_wdata          : r_wdata;

  // Next-state logic and the accept / enter-RESP strobes.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_enter_resp = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          w_accept = 1'b1;
          if (LATENCY == 1) begin
            w_next_state = RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_next_state = WAIT;
          end
        end else begin
          w_next_state = IDLE;
        end
      end
      WAIT: begin
        if (r_cnt == {CW{1'b0}}) begin
          w_next_state = RESP;
          w_enter_resp = 1'b1;
        end else begin
          w_next_state = WAIT;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = RESP;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // State register and latency counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= {CW{1'b0}};
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_cnt <= CW'(LATENCY - 1);
      end else if ((r_state == WAIT) && (r_cnt != {CW{1'b0}})) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  // Request fields captured at acceptance and held for the whole transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_write    <= 1'b0;
      r_unsigned <= 1'b0;
      r_err      <= 1'b0;
      r_size     <= SZ_B;
      r_lane     <= 3'd0;
      r_idx      <= {AW{1'b0}};
      r_wdata    <= 64'd0;
    end else if (w_accept) begin
      r_write    <= bus.req_write;
      r_unsigned <= bus.req_unsigned;
      r_err      <= w_req_err;
      r_size     <= bus.req_size;
      r_lane     <= bus.req_addr[2:0];
      r_idx      <= bus.req_addr[3 +: AW];
      r_wdata    <= bus.req_wdata;
    end
  end

  // Array port: store lanes are steered into place; nothing is written in reset.
  assign w_we = (w_enter_resp && w_cur_write && !w_cur_err && !rst) ?
                byte_mask(w_cur_size, w_cur_lane) : 8'h00;
  assign w_re = w_enter_resp && !w_cur_write;

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_addr  (w_cur_idx),
    .i_wdata (w_cur_wdata << {w_cur_lane, 3'b000}),
    .o_rdata (w_dout)
  );

  assign bus.req_ready = (r_state == IDLE);
  assign bus.rsp_valid = (r_state == RESP);
  assign bus.busy      = (r_state != IDLE);
  assign bus.rsp_err   = (r_state == RESP) && r_err;

  // Load data: shift the selected lane down and extend; zero otherwise.
  always_comb begin
    if ((r_state == RESP) && !r_write && !r_err) begin
      bus.rsp_rdata = load_extend(w_dout >> {r_lane, 3'b000}, r_size, r_unsigned);
    end else begin
      bus.rsp_rdata = 64'd0;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: scoreboard of expected responses,
// one task per scenario.
module tb_dmem_responder;
  import riscv_mem_pkg::*;

  localparam int DEPTH = 256;
  localparam int LAT   = 3;

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;
  exp_t sb[$];

  dmem_responder_if bus();

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Present a request and wait until it is accepted; optionally record the expected response.
  task automatic send(input logic wr, input logic [63:0] addr, input logic [1:0] size,
                      input logic uns, input logic [63:0] wdata, input logic push,
                      input logic [63:0] exp_rdata, input logic exp_err);
    exp_t e;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_write    = wr;
    bus.req_addr     = addr;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_wdata    = wdata;
    for (int c = 0; c < 50 && !bus.req_ready; c++) @(negedge clk);
    if (!bus.req_ready) begin
      n_vec++; n_bad++;
      $display("FAIL accept_timeout addr=%h req_ready=%b required 1", addr, bus.req_ready);
    end
    if (push) begin
      e.rdata = exp_rdata;
      e.err   = exp_err;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  // Wait for the response, check latency and payload against the scoreboard.
  task automatic collect(input string name);
    int   c;
    exp_t e;
    c = 0;
    while (!bus.rsp_valid && c < 50) begin
      @(posedge clk);
      #1;
      c++;
    end
    n_vec++;
    if (!bus.rsp_valid || c != LAT) begin
      n_bad++;
      $display("FAIL %s_latency got %0d cycles (valid=%b) required %0d", name, c, bus.rsp_valid, LAT);
    end
    if (!bus.rsp_valid) return;
    if (sb.size() == 0) begin
      n_vec++; n_bad++;
      $display("FAIL %s_scoreboard empty queue, required an entry", name);
      return;
    end
    e = sb.pop_front();
    n_vec++;
    if (bus.rsp_rdata !== e.rdata) begin
      n_bad++;
      $display("FAIL %s_rdata got %h required %h", name, bus.rsp_rdata, e.rdata);
    end
    n_vec++;
    if (bus.rsp_err !== e.err) begin
      n_bad++;
      $display("FAIL %s_err got %b required %b", name, bus.rsp_err, e.err);
    end
    if (bus.rsp_ready) begin
      @(posedge clk);
      #1;
      n_vec++;
      if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
        n_bad++;
        $display("FAIL %s_release valid=%b busy=%b required 0 0", name, bus.rsp_valid, bus.busy);
      end
    end
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = 64'd0;
    bus.req_size = SZ_B; bus.req_unsigned = 1'b0; bus.req_wdata = 64'd0;
    bus.rsp_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 64'd0 ||
        bus.rsp_err !== 1'b0 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs rdy=%b vld=%b rdata=%h err=%b busy=%b required 1 0 0 0 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_double();
    send(1'b1, 64'h10, SZ_D, 1'b0, 64'h1122334455667788, 1'b1, 64'd0, 1'b0);
    collect("st_d");
    send(1'b0, 64'h10, SZ_D, 1'b0, 64'd0, 1'b1, 64'h1122334455667788, 1'b0);
    collect("ld_d");
  endtask

  task automatic test_subword();
    send(1'b1, 64'h13, SZ_B, 1'b0, 64'hFFFF_FFFF_FFFF_FF80, 1'b1, 64'd0, 1'b0);
    collect("st_b");
    send(1'b0, 64'h13, SZ_B, 1'b0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
    collect("ld_b_s");
    send(1'b0, 64'h13, SZ_B, 1'b1, 64'd0, 1'b1, 64'h80, 1'b0);
    collect("ld_b_u");
    send(1'b0, 64'h10, SZ_D, 1'b1, 64'd0, 1'b1, 64'h1122334480667788, 1'b0);
    collect("ld_d_merge");
    send(1'b0, 64'h12, SZ_H, 1'b0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_8066, 1'b0);
    collect("ld_h_s");
    send(1'b0, 64'h14, SZ_W, 1'b1, 64'd0, 1'b1, 64'h0000_0000_1122_3344, 1'b0);
    collect("ld_w_u");
    send(1'b0, 64'h10, SZ_W, 1'b0, 64'd0, 1'b1, 64'hFFFF_FFFF_8066_7788, 1'b0);
    collect("ld_w_s");
  endtask

  task automatic test_errors();
    send(1'b1, 64'h7F8, SZ_D, 1'b0, 64'h0123456789ABCDEF, 1'b1, 64'd0, 1'b0);
    collect("st_top");
    send(1'b1, 64'h0, SZ_D, 1'b0, 64'h0F0E0D0C0B0A0908, 1'b1, 64'd0, 1'b0);
    collect("st_zero");
    send(1'b0, 64'h12, SZ_W, 1'b0, 64'd0, 1'b1, 64'd0, 1'b1);
    collect("ld_w_misal");
    send(1'b1, 64'(DEPTH * 8), SZ_D, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'd0, 1'b1);
    collect("st_range");
    send(1'b1, 64'h11, SZ_H, 1'b0, 64'hFFFF, 1'b1, 64'd0, 1'b1);
    collect("st_h_misal");
    send(1'b0, 64'h7F8, SZ_D, 1'b0, 64'd0, 1'b1, 64'h0123456789ABCDEF, 1'b0);
    collect("ld_top_unchanged");
    send(1'b0, 64'h0, SZ_D, 1'b0, 64'd0, 1'b1, 64'h0F0E0D0C0B0A0908, 1'b0);
    collect("ld_zero_unchanged");
    send(1'b0, 64'h10, SZ_D, 1'b0, 64'd0, 1'b1, 64'h1122334480667788, 1'b0);
    collect("ld_misal_unchanged");
    send(1'b0, 64'h7FF, SZ_B, 1'b1, 64'd0, 1'b1, 64'h01, 1'b0);
    collect("ld_last_byte");
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bus.rsp_ready = 1'b0;
    send(1'b0, 64'h10, SZ_D, 1'b0, 64'd0, 1'b1, 64'h1122334480667788, 1'b0);
    collect("bp_ld");
    // Next request held on the bus while the response is stalled.
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 64'h14;
    bus.req_size = SZ_W; bus.req_unsigned = 1'b1; bus.req_wdata = 64'd0;
    e.rdata = 64'h0000_0000_1122_3344; e.err = 1'b0;
    sb.push_back(e);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      n_vec++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 64'h1122334480667788 || bus.req_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold%0d vld=%b rdata=%h rdy=%b required 1 1122334480667788 0",
                 i, bus.rsp_valid, bus.rsp_rdata, bus.req_ready);
      end
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_release vld=%b rdy=%b required 0 1", bus.rsp_valid, bus.req_ready);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    n_vec++;
    if (bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_accept busy=%b required 1", bus.busy);
    end
    collect("b2b_ld");
  endtask

  task automatic test_reset_mid();
    send(1'b1, 64'h20, SZ_D, 1'b0, 64'h0000_0000_0000_CAFE, 1'b1, 64'd0, 1'b0);
    collect("st_old");
    send(1'b1, 64'h20, SZ_D, 1'b0, 64'h0000_0000_0000_DEAD, 1'b0, 64'd0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_vec++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 64'd0 ||
        bus.rsp_err !== 1'b0 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_outputs rdy=%b vld=%b rdata=%h err=%b busy=%b required 1 0 0 0 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.busy);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    send(1'b0, 64'h20, SZ_D, 1'b0, 64'd0, 1'b1, 64'h0000_0000_0000_CAFE, 1'b0);
    collect("ld_after_rst");
  endtask

  initial begin
    test_reset();
    test_double();
    test_subword();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
